hazard_scoreboard: RTL and testbench

Pipeline-side tracker that supplies the controller's `register_invalid` and `jump_state` inputs. It consumes the ID-stage write and branch decisions (`regwrite_cur`, `jump_inst`) and the per-stage enable/flush controls. It carries a small record for each in-flight instruction through EX, MEM and WB. From those records it reports which registers have a pending write and which branch condition has reached WB. It sits beside the pipeline registers of the 16-bit core and closes the loop with the controller.

---
 rtl/hazard_scoreboard.sv | 87 ++++++++
 tb/tb_hazard_scoreboard.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: carries a {wv, rd, jc} record per in-flight instruction
// through EX/MEM/WB and reports pending register writes and the WB branch code.
module hazard_scoreboard #(
    parameter int unsigned WB_VISIBLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] inst_id,
    input  logic        regwrite_cur,
    input  logic        regwrite_adr_controll,
    input  logic [2:0]  jump_inst,
    input  logic        en_ifid,
    input  logic        en_idex,
    input  logic        flush_idex,
    input  logic        en_exmem,
    input  logic        flush_exmem,
    input  logic        en_memwb,
    input  logic        flush_memwb,
    output logic [7:0]  register_invalid,
    output logic [2:0]  jump_state,
    output logic [1:0]  pending,
    output logic [15:0] stall_count
);

    // Slot layout: [6] write valid, [5:3] destination register, [2:0] branch code
    localparam int WV = 6;

    logic [6:0]  ex_q, ex_d;
    logic [6:0]  mem_q, mem_d;
    logic [6:0]  wb_q, wb_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic [2:0]  rd_sel;

    // Only the register fields of the instruction matter here
    logic unused_inst;
    assign unused_inst = ^{inst_id[15:14], inst_id[7:0]};

    // Next-state for the three slots and the stall counter; flush beats enable
    always_comb begin
        rd_sel = regwrite_adr_controll ? inst_id[13:11] : inst_id[10:8];

        ex_d = ex_q;
        if (flush_idex)    ex_d = 7'd0;
        else if (en_idex)  ex_d = {regwrite_cur, rd_sel, jump_inst};

        mem_d = mem_q;
        if (flush_exmem)   mem_d = 7'd0;
        else if (en_exmem) mem_d = ex_q;

        wb_d = wb_q;
        if (flush_memwb)   wb_d = 7'd0;
        else if (en_memwb) wb_d = mem_q;

        stall_count_d = stall_count_q;
        if (!en_ifid && stall_count_q != 16'hFFFF)
            stall_count_d = stall_count_q + 16'd1;
    end

    // State registers; reset drops every in-flight record at once
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q          <= 7'd0;
            mem_q         <= 7'd0;
            wb_q          <= 7'd0;
            stall_count_q <= 16'd0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Outputs decoded from slot registers only, so no input-to-output path
    always_comb begin
        register_invalid = 8'd0;
        if (ex_q[WV])  register_invalid[ex_q[5:3]]  = 1'b1;
        if (mem_q[WV]) register_invalid[mem_q[5:3]] = 1'b1;
        if (WB_VISIBLE != 0 && wb_q[WV]) register_invalid[wb_q[5:3]] = 1'b1;

        pending = {1'b0, ex_q[WV]} + {1'b0, mem_q[WV]} + {1'b0, wb_q[WV]};
        jump_state = wb_q[2:0];
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: two instances (WB visible / hidden)
// checked every cycle against an in-flight-instruction model, plus literals.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] inst_id;
    logic        regwrite_cur, regwrite_adr_controll;
    logic [2:0]  jump_inst;
    logic        en_ifid, en_idex, flush_idex, en_exmem, flush_exmem, en_memwb, flush_memwb;

    logic [7:0]  inv_v, inv_h;
    logic [2:0]  js_v, js_h;
    logic [1:0]  pend_v, pend_h;
    logic [15:0] sc_v, sc_h;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.WB_VISIBLE(1)) u_vis (
        .clk(clk), .reset(reset), .inst_id(inst_id), .regwrite_cur(regwrite_cur),
        .regwrite_adr_controll(regwrite_adr_controll), .jump_inst(jump_inst),
        .en_ifid(en_ifid), .en_idex(en_idex), .flush_idex(flush_idex),
        .en_exmem(en_exmem), .flush_exmem(flush_exmem),
        .en_memwb(en_memwb), .flush_memwb(flush_memwb),
        .register_invalid(inv_v), .jump_state(js_v), .pending(pend_v), .stall_count(sc_v));

    hazard_scoreboard #(.WB_VISIBLE(0)) u_hid (
        .clk(clk), .reset(reset), .inst_id(inst_id), .regwrite_cur(regwrite_cur),
        .regwrite_adr_controll(regwrite_adr_controll), .jump_inst(jump_inst),
        .en_ifid(en_ifid), .en_idex(en_idex), .flush_idex(flush_idex),
        .en_exmem(en_exmem), .flush_exmem(flush_exmem),
        .en_memwb(en_memwb), .flush_memwb(flush_memwb),
        .register_invalid(inv_h), .jump_state(js_h), .pending(pend_h), .stall_count(sc_h));

    // Model: each pipeline position (0=EX,1=MEM,2=WB) holds an instruction
    // descriptor; outputs are derived by scanning the occupied positions.
    typedef struct {
        bit       writes;
        int       dest;
        int       branch;
    } instr_t;

    instr_t pos[3];
    int     m_stalls;

    function automatic instr_t empty_instr();
        instr_t e;
        e.writes = 1'b0; e.dest = 0; e.branch = 0;
        return e;
    endfunction

    task automatic model_step();
        bit     fl[3];
        bit     en[3];
        instr_t nxt[3];
        instr_t incoming;
        fl = '{flush_idex, flush_exmem, flush_memwb};
        en = '{en_idex, en_exmem, en_memwb};
        incoming.writes = regwrite_cur;
        incoming.dest   = regwrite_adr_controll ? int'(inst_id[13:11]) : int'(inst_id[10:8]);
        incoming.branch = int'(jump_inst);
        if (reset) begin
            for (int s = 0; s < 3; s++) pos[s] = empty_instr();
            m_stalls = 0;
        end else begin
            for (int s = 0; s < 3; s++) begin
                if (fl[s])      nxt[s] = empty_instr();
                else if (en[s]) nxt[s] = (s == 0) ? incoming : pos[s-1];
                else            nxt[s] = pos[s];
            end
            pos = nxt;
            if (!en_ifid && m_stalls < 65535) m_stalls++;
        end
    endtask

    function automatic int exp_inv(bit wb_vis);
        int v = 0;
        for (int s = 0; s < 3; s++)
            if (pos[s].writes && (s < 2 || wb_vis)) v |= (1 << pos[s].dest);
        return v;
    endfunction

    function automatic int exp_pend();
        int n = 0;
        for (int s = 0; s < 3; s++) if (pos[s].writes) n++;
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_inv_vis", int'(inv_v), exp_inv(1'b1));
            chk("cyc_inv_hid", int'(inv_h), exp_inv(1'b0));
            chk("cyc_js_vis", int'(js_v), pos[2].branch);
            chk("cyc_js_hid", int'(js_h), pos[2].branch);
            chk("cyc_pend_vis", int'(pend_v), exp_pend());
            chk("cyc_pend_hid", int'(pend_h), exp_pend());
            chk("cyc_stall", int'(sc_v), m_stalls);
            chk("cyc_stall_h", int'(sc_h), m_stalls);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_run();
        en_ifid = 1; en_idex = 1; en_exmem = 1; en_memwb = 1;
        flush_idex = 0; flush_exmem = 0; flush_memwb = 0;
    endtask

    int c_v, c_h, peak;

    initial begin
        reset = 1; inst_id = 16'h0000; regwrite_cur = 0; regwrite_adr_controll = 0;
        jump_inst = 0;
        set_run();
        for (int s = 0; s < 3; s++) pos[s] = empty_instr();
        m_stalls = 0;
        tick();
        chk_en = 1'b1;
        reset = 0;

        // Reset: fill all slots with writes to r3, then reset
        inst_id = 16'h0300; regwrite_cur = 1;
        repeat (3) tick();
        chk("pre_inv", int'(inv_v), 8'h08);
        chk("pre_pend", int'(pend_v), 3);
        reset = 1; regwrite_cur = 0;
        tick();
        reset = 0;
        chk("rst_inv", int'(inv_v), 0);
        chk("rst_pend", int'(pend_v), 0);
        chk("rst_stall", int'(sc_v), 0);
        chk("rst_js", int'(js_v), 0);

        // ALU write to rb=1
        inst_id = 16'hC100; regwrite_adr_controll = 0; regwrite_cur = 1;
        tick();
        regwrite_cur = 0;
        c_v = 0; c_h = 0;
        for (int i = 0; i < 6; i++) begin
            if (inv_v == 8'h02) c_v++;
            if (inv_h == 8'h02) c_h++;
            tick();
        end
        chk("alu_cycles_vis", c_v, 3);
        chk("alu_cycles_hid", c_h, 2);

        // Overlapping writes to r5: LD then ALU
        inst_id = 16'h2800; regwrite_adr_controll = 1; regwrite_cur = 1;
        tick();
        c_v = inv_v[5]; c_h = inv_h[5]; peak = pend_v;
        inst_id = 16'h0500; regwrite_adr_controll = 0;
        tick();
        regwrite_cur = 0;
        for (int i = 0; i < 6; i++) begin
            if (inv_v[5]) c_v++;
            if (inv_h[5]) c_h++;
            if (pend_v > peak) peak = pend_v;
            tick();
        end
        chk("ovl_cycles_vis", c_v, 4);
        chk("ovl_cycles_hid", c_h, 3);
        chk("ovl_peak", peak, 2);

        // Stall with EX bubble while r2 write is in EX
        inst_id = 16'h0200; regwrite_cur = 1;
        tick();
        regwrite_cur = 0; flush_idex = 1; en_ifid = 0;
        tick();
        chk("stl1_inv", int'(inv_v), 8'h04);
        chk("stl1_pend", int'(pend_v), 1);
        tick();
        chk("stl2_inv_vis", int'(inv_v), 8'h04);
        chk("stl2_inv_hid", int'(inv_h), 8'h00);
        chk("stl2_count", int'(sc_v), 2);
        set_run();
        repeat (3) tick();

        // Branch BE at edge N, plus a write that gets flushed
        jump_inst = 3'd2;
        tick();
        jump_inst = 0;
        chk("br_n1", int'(js_v), 0);
        inst_id = 16'h0700; regwrite_cur = 1;
        tick();
        regwrite_cur = 0;
        chk("br_n2", int'(js_v), 0);
        tick();
        chk("br_n3", int'(js_v), 2);
        chk("br_n3_inv", int'(inv_v), 8'h80);
        flush_idex = 1; flush_exmem = 1; flush_memwb = 1;
        tick();
        set_run();
        chk("br_n4_js", int'(js_v), 0);
        chk("br_n4_inv", int'(inv_v), 0);
        chk("br_n4_pend", int'(pend_v), 0);
        chk("br_stall_kept", int'(sc_v), 2);

        // Saturation
        en_ifid = 0;
        repeat (65532) tick();
        chk("sat_below", int'(sc_v), 16'hFFFE);
        tick();
        chk("sat_hit", int'(sc_v), 16'hFFFF);
        repeat (7) tick();
        chk("sat_hold", int'(sc_v), 16'hFFFF);
        en_ifid = 1; reset = 1;
        tick();
        reset = 0;
        chk("sat_rst", int'(sc_v), 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
